// File: rtl/micro_seq_ctrl.sv
// micro_seq_ctrl: fetch/decode/execute sequencer for the 8-bit accumulator micro
module micro_seq_ctrl #(
  parameter int n       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic [n-1:0] i_Instruction,
  input  logic         i_MemAck,
  input  logic         i_Zero,
  input  logic         i_Run,
  output logic         o_MemReq,
  output logic         o_MemWe,
  output logic         o_AddrSel,
  output logic         o_IR_Load,
  output logic         o_PC_Inc,
  output logic         o_PC_Load,
  output logic         o_ImmSel,
  output logic [1:0]   o_ALU_Op,
  output logic         o_AccSrc,
  output logic         o_ACC_Load,
  output logic         o_Halted,
  output logic         o_Fault,
  output logic         o_IllegalOp,
  output logic [2:0]   o_State
);
  typedef enum logic [2:0] {HALT = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, FAULT = 3'd5} state_t;
  localparam logic [n-4:0] OP_NOP  = (n-3)'(0);
  localparam logic [n-4:0] OP_LDI  = (n-3)'(1);
  localparam logic [n-4:0] OP_ADDI = (n-3)'(2);
  localparam logic [n-4:0] OP_SUBI = (n-3)'(3);
  localparam logic [n-4:0] OP_LDM  = (n-3)'(4);
  localparam logic [n-4:0] OP_STM  = (n-3)'(5);
  localparam logic [n-4:0] OP_JMP  = (n-3)'(6);
  localparam logic [n-4:0] OP_JZ   = (n-3)'(7);
  localparam logic [7:0]   WD_LAST = 8'(TIMEOUT - 1);
  state_t         state_q, state_d;
  logic [n-1:0]   ir_q, ir_d;
  logic [7:0]     wd_q, wd_d;
  logic           run_q;
  logic [n-4:0]   op;
  logic           run_rise, bus, wd_expired, alu_op, illegal;
  assign op         = ir_q[n-1:3];
  assign run_rise   = i_Run & ~run_q;
  assign bus        = (state_q == FETCH) | (state_q == MEM);
  assign wd_expired = ~i_MemAck & (wd_q == WD_LAST);
  assign alu_op     = (op == OP_LDI) | (op == OP_ADDI) | (op == OP_SUBI);
  assign illegal    = ~alu_op & (op != OP_NOP) & (op != OP_JMP) & (op != OP_JZ) & (op != OP_LDM) & (op != OP_STM) & ~(&op);
  // State, instruction, watchdog and run-edge registers
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= HALT;
      ir_q    <= '0;
      wd_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wd_q    <= wd_d;
      run_q   <= i_Run;
    end
  end
  // Next state, IR capture and watchdog update; the watchdog restarts on any state change
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      HALT:    state_d = run_rise ? FETCH : HALT;
      FETCH: begin
        state_d = i_MemAck ? DECODE : (wd_expired ? FAULT : FETCH);
        ir_d    = i_MemAck ? i_Instruction : ir_q;
      end
      DECODE:  state_d = ((op == OP_LDM) | (op == OP_STM)) ? MEM : ((&op) ? HALT : EXEC);
      EXEC:    state_d = FETCH;
      MEM:     state_d = i_MemAck ? FETCH : (wd_expired ? FAULT : MEM);
      FAULT:   state_d = FAULT;
      default: state_d = HALT;
    endcase
    wd_d = (state_d != state_q) ? '0 : ((bus & ~i_MemAck) ? wd_q + 8'd1 : wd_q);
  end
  assign o_MemReq    = bus;
  assign o_AddrSel   = state_q == MEM;
  assign o_MemWe     = (state_q == MEM) & (op == OP_STM);
  assign o_IR_Load   = (state_q == FETCH) & i_MemAck;
  assign o_PC_Inc    = o_IR_Load;
  assign o_PC_Load   = (state_q == EXEC) & ((op == OP_JMP) | ((op == OP_JZ) & i_Zero));
  assign o_ImmSel    = (state_q == EXEC) & alu_op;
  assign o_ALU_Op    = (state_q != EXEC) ? 2'b00 : ((op == OP_ADDI) ? 2'b01 : ((op == OP_SUBI) ? 2'b10 : 2'b00));
  assign o_AccSrc    = (state_q == MEM) & i_MemAck & (op == OP_LDM);
  assign o_ACC_Load  = o_ImmSel | o_AccSrc;
  assign o_Halted    = state_q == HALT;
  assign o_Fault     = state_q == FAULT;
  assign o_IllegalOp = (state_q == EXEC) & illegal;
  assign o_State     = state_q;
endmodule
